// File: rtl/bus_ctrl.sv
// bus_ctrl: responder end of the core memory/GPIO grant handshake.
// Round-robin arbitration among NUM_CORES requesters. One access is served at
// a time against a shared byte RAM or a small GPIO register window. Each access
// takes three cycles: IDLE (sample/arbitrate), ACCESS, RESP (grant pulse).
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   grant_request  per-core request, held until granted
//   rw             per-core direction, 1 = write, 0 = read
//   address        per-core 9-bit address, bit 8 selects GPIO; core i at [9i+8:9i]
//   data_out       per-core write data; core i at [8i+7:8i]
//   grant_given    one-hot completion pulse, one cycle, in RESP
//   data_in        read data, valid while a grant_given bit is high
//   load_en        program-load write strobe, independent of the FSM
//   load_addr      program-load address
//   load_data      program-load data
//   gpio_in        external inputs, asynchronous to clk
//   gpio_out       GPIO output register
//   busy           high in ACCESS and RESP
//
// state  | meaning
// IDLE   | waiting; picks the next requester after rr_ptr and latches its request
// ACCESS | performs the latched RAM/GPIO access
// RESP   | drives grant_given and data_in for the served core

module bus_ctrl #(
  parameter int NUM_CORES = 2,
  parameter int RAM_AW    = 8,
  parameter int GPIO_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CORES-1:0]   grant_request,
  input  logic [NUM_CORES-1:0]   rw,
  input  logic [9*NUM_CORES-1:0] address,
  input  logic [8*NUM_CORES-1:0] data_out,
  output logic [NUM_CORES-1:0]   grant_given,
  output logic [7:0]             data_in,
  input  logic                   load_en,
  input  logic [RAM_AW-1:0]      load_addr,
  input  logic [7:0]             load_data,
  input  logic [GPIO_W-1:0]      gpio_in,
  output logic [GPIO_W-1:0]      gpio_out,
  output logic                   busy
);

  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int XW = (GPIO_W > 8) ? GPIO_W : 8;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_nx;

  // rr_ptr doubles as the index of the core being served once latched
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   win;
  logic            win_valid;
  logic            lat_rw;
  logic [8:0]      lat_addr;
  logic [7:0]      lat_wdata;
  logic [7:0]      ram [2**RAM_AW];
  logic [GPIO_W-1:0] gpio_meta, gpio_sync;
  logic [XW-1:0]   gpio_out_ext, gpio_sync_ext, wdata_ext;
  logic [7:0]      rdata;
  logic            ram_we;
  logic            gpio_we;

  assign gpio_out_ext  = XW'(gpio_out);
  assign gpio_sync_ext = XW'(gpio_sync);
  assign wdata_ext     = XW'(lat_wdata);

  // First requester strictly after rr_ptr, wrapping modulo NUM_CORES
  always_comb begin
    win       = '0;
    win_valid = 1'b0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      if (!win_valid && grant_request[(int'(rr_ptr) + k) % NUM_CORES]) begin
        win_valid = 1'b1;
        win       = PW'((int'(rr_ptr) + k) % NUM_CORES);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    ram_we   = 1'b0;
    gpio_we  = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid) state_nx = ACCESS;
      end
      ACCESS: begin
        busy     = 1'b1;
        ram_we   = lat_rw && !lat_addr[8];
        gpio_we  = lat_rw && lat_addr[8] && (lat_addr[7:0] == 8'h00);
        state_nx = RESP;
      end
      RESP: begin
        busy     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rdata = 8'h00;
    if (lat_addr[8]) begin
      if (lat_addr[7:0] == 8'h00)      rdata = gpio_out_ext[7:0];
      else if (lat_addr[7:0] == 8'h01) rdata = gpio_sync_ext[7:0];
    end else begin
      rdata = ram[lat_addr[RAM_AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= PW'(NUM_CORES - 1);
      lat_rw    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (state == IDLE && win_valid) begin
      rr_ptr    <= win;
      lat_rw    <= rw[win];
      lat_addr  <= address[9*win +: 9];
      lat_wdata <= data_out[8*win +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_given <= '0;
      data_in     <= 8'h00;
      gpio_out    <= '0;
      gpio_meta   <= '0;
      gpio_sync   <= '0;
    end else begin
      gpio_meta   <= gpio_in;
      gpio_sync   <= gpio_meta;
      grant_given <= '0;
      data_in     <= 8'h00;
      if (state == ACCESS) begin
        grant_given[rr_ptr] <= 1'b1;
        data_in             <= lat_rw ? 8'h00 : rdata;
      end
      if (gpio_we) gpio_out <= wdata_ext[GPIO_W-1:0];
    end
  end

  // Program load comes last so it wins a same-address collision;
  // a same-edge read already captured the old value through rdata.
  always_ff @(posedge clk) begin
    if (ram_we)  ram[lat_addr[RAM_AW-1:0]] <= lat_wdata;
    if (load_en) ram[load_addr]            <= load_data;
  end

endmodule

// File: tb/tb_bus_ctrl.sv
module tb_bus_ctrl;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   grant_request = '0;
  logic [N-1:0]   rw = '0;
  logic [9*N-1:0] address = '0;
  logic [8*N-1:0] data_out = '0;
  logic [N-1:0]   grant_given;
  logic [7:0]     data_in;
  logic           load_en = 1'b0;
  logic [7:0]     load_addr = '0;
  logic [7:0]     load_data = '0;
  logic [7:0]     gpio_in = '0;
  logic [7:0]     gpio_out;
  logic           busy;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] ram_m [256];
  logic [7:0] gpio_out_m = 8'h00;
  logic [7:0] gpio_in_m = 8'h00;

  logic       op_rw   [N];
  logic [8:0] op_addr [N];
  logic [7:0] op_wd   [N];
  bit         pend    [N];

  bus_ctrl #(.NUM_CORES(N), .RAM_AW(8), .GPIO_W(8)) dut (
    .clk(clk), .reset(reset), .grant_request(grant_request), .rw(rw),
    .address(address), .data_out(data_out), .grant_given(grant_given),
    .data_in(data_in), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .gpio_in(gpio_in), .gpio_out(gpio_out), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1);
  end

  task automatic do_reset();
    reset = 1'b1;
    grant_request = '0;
    load_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    gpio_out_m = 8'h00;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    @(posedge clk);
    #1;
    load_en = 1'b0;
    ram_m[a] = d;
  endtask

  task automatic post(input int c, input logic w, input logic [8:0] a, input logic [7:0] d);
    rw[c] = w;
    address[9*c +: 9] = a;
    data_out[8*c +: 8] = d;
    grant_request[c] = 1'b1;
  endtask

  task automatic wait_grant(output int cyc, output logic [N-1:0] g, output logic [7:0] d, output bit ok);
    ok = 1'b0;
    g = '0;
    d = '0;
    cyc = 0;
    for (int i = 1; i <= 12 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (grant_given != '0) begin
        cyc = i;
        g = grant_given;
        d = data_in;
        grant_request = grant_request & ~grant_given;
        ok = 1'b1;
      end
    end
  endtask

  function automatic logic [7:0] model_read(input logic [8:0] a);
    if (a[8]) begin
      if (a[7:0] == 8'h00) return gpio_out_m;
      if (a[7:0] == 8'h01) return gpio_in_m;
      return 8'h00;
    end
    return ram_m[a[7:0]];
  endfunction

  task automatic test_reset();
    do_reset();
    n_cmp++; if (grant_given !== 2'b00) begin n_fail++; $display("FAIL rst_grant: got %b want 00", grant_given); end
    n_cmp++; if (data_in !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", data_in); end
    n_cmp++; if (gpio_out !== 8'h00) begin n_fail++; $display("FAIL rst_gpio_out: got %h want 00", gpio_out); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
  endtask

  task automatic test_load_read();
    int cyc; logic [N-1:0] g; logic [7:0] d; bit ok;
    load(8'h00, 8'h01); load(8'h01, 8'h02); load(8'h02, 8'h03); load(8'h03, 8'h04);
    post(0, 1'b0, 9'h002, 8'h00);
    wait_grant(cyc, g, d, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rd_timeout: got no grant want grant"); end
    n_cmp++; if (cyc != 2) begin n_fail++; $display("FAIL rd_latency: got grant after %0d edges want 2 (3rd cycle)", cyc); end
    n_cmp++; if (g !== 2'b01) begin n_fail++; $display("FAIL rd_grant: got %b want 01", g); end
    n_cmp++; if (d !== 8'h03) begin n_fail++; $display("FAIL rd_data: got %h want 03", d); end
  endtask

  task automatic test_write_read();
    int cyc; logic [N-1:0] g; logic [7:0] d; bit ok;
    post(1, 1'b1, 9'h010, 8'hA5);
    wait_grant(cyc, g, d, ok);
    ram_m[8'h10] = 8'hA5;
    n_cmp++; if (!ok || g !== 2'b10) begin n_fail++; $display("FAIL wr_grant: got %b want 10", g); end
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL wr_data_zero: got %h want 00", d); end
    post(1, 1'b0, 9'h010, 8'h00);
    wait_grant(cyc, g, d, ok);
    n_cmp++; if (!ok || g !== 2'b10) begin n_fail++; $display("FAIL wrrd_grant: got %b want 10", g); end
    n_cmp++; if (d !== 8'hA5) begin n_fail++; $display("FAIL wrrd_data: got %h want a5", d); end
  endtask

  task automatic test_fairness();
    int gcount, last;
    logic [N-1:0] prev, expg;
    do_reset();
    post(0, 1'b0, 9'h000, 8'h00);
    post(1, 1'b0, 9'h001, 8'h00);
    gcount = 0; last = 0; prev = '0;
    for (int cyc = 1; cyc <= 40 && gcount < 8; cyc++) begin
      @(posedge clk);
      #1;
      if (prev != '0) begin
        n_cmp++; if (grant_given !== 2'b00) begin n_fail++; $display("FAIL rr_pulse: got %b want 00 after a grant", grant_given); end
      end
      if (grant_given != '0) begin
        expg = (gcount % 2 == 0) ? 2'b01 : 2'b10;
        n_cmp++; if (grant_given !== expg) begin n_fail++; $display("FAIL rr_order[%0d]: got %b want %b", gcount, grant_given, expg); end
        n_cmp++; if (data_in !== ram_m[gcount % 2]) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", gcount, data_in, ram_m[gcount % 2]); end
        if (gcount > 0) begin
          n_cmp++; if (cyc - last != 3) begin n_fail++; $display("FAIL rr_period: got %0d want 3", cyc - last); end
        end
        last = cyc;
        gcount++;
      end
      prev = grant_given;
    end
    grant_request = '0;
    n_cmp++; if (gcount != 8) begin n_fail++; $display("FAIL rr_count: got %0d want 8", gcount); end
    @(posedge clk);
    #1;
    n_cmp++; if (grant_given !== 2'b00) begin n_fail++; $display("FAIL rr_last_pulse: got %b want 00", grant_given); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_gpio();
    int cyc; logic [N-1:0] g; logic [7:0] d; bit ok;
    post(0, 1'b1, 9'h100, 8'h3C);
    wait_grant(cyc, g, d, ok);
    gpio_out_m = 8'h3C;
    n_cmp++; if (!ok || g !== 2'b01) begin n_fail++; $display("FAIL gpio_wr_grant: got %b want 01", g); end
    n_cmp++; if (gpio_out !== 8'h3C) begin n_fail++; $display("FAIL gpio_out: got %h want 3c", gpio_out); end
    gpio_in = 8'h5A; gpio_in_m = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    post(0, 1'b0, 9'h101, 8'h00);
    wait_grant(cyc, g, d, ok);
    n_cmp++; if (!ok || d !== 8'h5A) begin n_fail++; $display("FAIL gpio_in_rd: got %h want 5a", d); end
    post(1, 1'b0, 9'h1FF, 8'h00);
    wait_grant(cyc, g, d, ok);
    n_cmp++; if (!ok || d !== 8'h00) begin n_fail++; $display("FAIL gpio_hole_rd: got %h want 00", d); end
    post(1, 1'b0, 9'h100, 8'h00);
    wait_grant(cyc, g, d, ok);
    n_cmp++; if (!ok || d !== 8'h3C) begin n_fail++; $display("FAIL gpio_out_rd: got %h want 3c", d); end
  endtask

  task automatic test_reset_mid();
    int cyc; logic [N-1:0] g; logic [7:0] d; bit ok;
    do_reset();
    load(8'h20, 8'h11);
    load(8'h02, 8'h03);
    post(0, 1'b1, 9'h020, 8'h77);
    @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_access: got %b want 1", busy); end
    reset = 1'b1;
    #1;
    n_cmp++; if (grant_given !== 2'b00) begin n_fail++; $display("FAIL mid_grant: got %b want 00", grant_given); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    grant_request = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    gpio_out_m = 8'h00;
    post(0, 1'b0, 9'h020, 8'h00);
    post(1, 1'b0, 9'h002, 8'h00);
    wait_grant(cyc, g, d, ok);
    n_cmp++; if (!ok || g !== 2'b01) begin n_fail++; $display("FAIL mid_rr_restore: got %b want 01", g); end
    n_cmp++; if (d !== 8'h11) begin n_fail++; $display("FAIL mid_ram_kept: got %h want 11", d); end
    wait_grant(cyc, g, d, ok);
    n_cmp++; if (!ok || g !== 2'b10 || d !== 8'h03) begin n_fail++; $display("FAIL mid_second: got %b/%h want 10/03", g, d); end
    post(1, 1'b0, 9'h002, 8'h00);
    wait_grant(cyc, g, d, ok);
    n_cmp++; if (!ok || g !== 2'b10) begin n_fail++; $display("FAIL resp_grant: got %b want 10", g); end
    reset = 1'b1;
    #1;
    n_cmp++; if (grant_given !== 2'b00 || data_in !== 8'h00) begin n_fail++; $display("FAIL resp_async_drop: got %b/%h want 00/00", grant_given, data_in); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_load_collision();
    int cyc; logic [N-1:0] g; logic [7:0] d; bit ok;
    do_reset();
    load(8'h30, 8'h00);
    load(8'h31, 8'h12);
    post(1, 1'b1, 9'h030, 8'h77);
    @(posedge clk); #1;
    load_en = 1'b1; load_addr = 8'h30; load_data = 8'hEE;
    @(posedge clk); #1;
    load_en = 1'b0; ram_m[8'h30] = 8'hEE;
    n_cmp++; if (grant_given !== 2'b10) begin n_fail++; $display("FAIL coll_wr_grant: got %b want 10", grant_given); end
    grant_request[1] = 1'b0;
    @(posedge clk); #1;
    post(0, 1'b0, 9'h031, 8'h00);
    @(posedge clk); #1;
    load_en = 1'b1; load_addr = 8'h31; load_data = 8'h34;
    @(posedge clk); #1;
    load_en = 1'b0;
    n_cmp++; if (grant_given !== 2'b01 || data_in !== 8'h12) begin n_fail++; $display("FAIL coll_rd_old: got %b/%h want 01/12", grant_given, data_in); end
    ram_m[8'h31] = 8'h34;
    grant_request[0] = 1'b0;
    @(posedge clk); #1;
    post(0, 1'b0, 9'h030, 8'h00);
    wait_grant(cyc, g, d, ok);
    n_cmp++; if (!ok || d !== 8'hEE) begin n_fail++; $display("FAIL coll_load_wins: got %h want ee", d); end
    post(1, 1'b0, 9'h031, 8'h00);
    wait_grant(cyc, g, d, ok);
    n_cmp++; if (!ok || d !== 8'h34) begin n_fail++; $display("FAIL coll_rd_new: got %h want 34", d); end
  endtask

  task automatic arm(input int c);
    int sel, sub;
    logic [7:0] a8;
    op_rw[c] = 1'($urandom_range(1, 0));
    sel = $urandom_range(3, 0);
    if (sel == 0) begin
      sub = $urandom_range(2, 0);
      a8 = (sub == 0) ? 8'h00 : (sub == 1) ? 8'h01 : 8'($urandom_range(255, 0));
      op_addr[c] = {1'b1, a8};
    end else begin
      op_addr[c] = {1'b0, 8'($urandom_range(255, 0))};
    end
    op_wd[c] = 8'($urandom_range(255, 0));
    pend[c] = 1'b1;
    post(c, op_rw[c], op_addr[c], op_wd[c]);
  endtask

  task automatic test_random();
    int cyc, lg, e;
    logic [N-1:0] g, expg;
    logic [7:0] d, expd;
    bit ok, found, any;
    do_reset();
    for (int a = 0; a < 256; a++) load(8'(a), 8'($urandom_range(255, 0)));
    gpio_in = 8'($urandom_range(255, 0));
    gpio_in_m = gpio_in;
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) pend[c] = 1'b0;
    for (int c = 0; c < N; c++) if ($urandom_range(1, 0) == 1) arm(c);
    any = 1'b0;
    for (int c = 0; c < N; c++) if (pend[c]) any = 1'b1;
    if (!any) arm($urandom_range(N - 1, 0));
    lg = N - 1;
    for (int it = 0; it < 60; it++) begin
      wait_grant(cyc, g, d, ok);
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL rnd_timeout[%0d]: got no grant want grant", it); break; end
      found = 1'b0; e = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && pend[(lg + k) % N]) begin found = 1'b1; e = (lg + k) % N; end
      end
      expg = '0;
      expg[e] = 1'b1;
      expd = op_rw[e] ? 8'h00 : model_read(op_addr[e]);
      n_cmp++; if (g !== expg) begin n_fail++; $display("FAIL rnd_grant[%0d]: got %b want %b", it, g, expg); end
      n_cmp++; if (d !== expd) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h addr %h", it, d, expd, op_addr[e]); end
      n_cmp++; if (cyc != ((it == 0) ? 2 : 3)) begin n_fail++; $display("FAIL rnd_timing[%0d]: got %0d want %0d", it, cyc, (it == 0) ? 2 : 3); end
      if (op_rw[e]) begin
        if (!op_addr[e][8]) ram_m[op_addr[e][7:0]] = op_wd[e];
        else if (op_addr[e][7:0] == 8'h00) gpio_out_m = op_wd[e];
      end
      n_cmp++; if (gpio_out !== gpio_out_m) begin n_fail++; $display("FAIL rnd_gpio_out[%0d]: got %h want %h", it, gpio_out, gpio_out_m); end
      pend[e] = 1'b0;
      grant_request[e] = 1'b0;
      for (int c = 0; c < N; c++) if (pend[c]) grant_request[c] = 1'b1;
      lg = e;
      if ($urandom_range(3, 0) == 0) begin
        gpio_in = 8'($urandom_range(255, 0));
        gpio_in_m = gpio_in;
      end
      for (int c = 0; c < N; c++) if (!pend[c] && $urandom_range(1, 0) == 1) arm(c);
      any = 1'b0;
      for (int c = 0; c < N; c++) if (pend[c]) any = 1'b1;
      if (!any) arm($urandom_range(N - 1, 0));
    end
    grant_request = '0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_write_read();
    test_fairness();
    test_gpio();
    test_reset_mid();
    test_load_collision();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
